fp32_add_arbiter: RTL
=====================

Name: fp32_add_arbiter

Overview:
- Shares one combinational single-precision adder (`fp32_add`, instantiated by the parent) between NREQ requesters.
- Accepts one operand pair at a time using round-robin arbitration.
- Drives the adder from registered operands, captures the sum, and returns it with the requester ID over a valid/ready response channel.
- Sits between the compute lanes and the single adder instance in the FP datapath.

Parameters:
- NREQ, 4, number of requesters (2..16).
- ID_W, $clog2(NREQ), width of requester ID; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester operand valid.
- req_ready  output  NREQ  per-requester accept; at most one bit high.
- req_a  input  NREQ*32  packed operand A; requester i at [32*i+31:32*i].
- req_b  input  NREQ*32  packed operand B, same packing.
- add_a  output  32  operand A to shared adder.
- add_b  output  32  operand B to shared adder.
- add_y  input  32  adder result, combinational from add_a/add_b.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  result accept.
- rsp_y  output  32  sum.
- rsp_id  output  ID_W  index of requester that issued the operation.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, rr_ptr=0, add_a=add_b=0, rsp_valid=0, rsp_y=0, rsp_id=0, busy=0, req_ready=0.
- Reset mid-operation: any in-flight transaction is dropped and no response is issued. Requesters must re-present.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grantee g is the first i with req_valid[i]=1, searching from rr_ptr upward and wrapping modulo NREQ.
  - req_ready = onehot(g) when any valid, else 0. This is combinational from req_valid.
  - Requesters must not gate valid on ready; once asserted, valid must hold until the handshake.
  - On handshake (req_valid[g] & req_ready[g]) at a clock edge: add_a<=req_a[g], add_b<=req_b[g], id<=g, rr_ptr<=(g+1) mod NREQ, state<=EXEC.
- EXEC (1 cycle):
  - add_a/add_b are stable from registers.
  - rsp_y<=add_y, rsp_id<=id, rsp_valid<=1, state<=RESP.
- RESP:
  - rsp_valid=1. rsp_y, rsp_id, add_a and add_b are held stable.
  - req_ready=0 for all requesters.
  - On rsp_ready=1: rsp_valid<=0, state<=IDLE. A new grant is possible in the following cycle.
- Latency: request handshake at edge N → rsp_valid high after edge N+1. With rsp_ready tied high, the response is consumed at edge N+2.
  - Peak throughput is one operation per 3 cycles.
- rr_ptr updates only on a grant. Requests that are not granted are not acknowledged and are not lost.
- No arithmetic is done in this block. rsp_y is bit-exact add_y, including the adder's zero pass-through and Inf saturation.
- Simultaneous events:
  - New requests arriving while busy wait; they are never accepted outside IDLE.
  - rsp_ready asserted in EXEC has no effect.
- Wrap-around: rr_ptr=NREQ-1 with grant to NREQ-1 sets rr_ptr=0.

Test Plan:
- Single op: req_valid=0001, req_a[0]=0x3F800000 (1.0), req_b[0]=0x40000000 (2.0), rsp_ready=1 → req_ready=0001 in cycle 0; rsp_valid in cycle 2 with rsp_y=0x40400000, rsp_id=0; busy high for 2 cycles.
- Fairness: all four req_valid held high, each presenting new operands after its grant, rsp_ready=1 → grant order 0,1,2,3,0,1; one grant every 3 cycles; req_ready never multi-hot.
- Backpressure: requester 2 issues 0x3FC00000 + 0x40200000 with rsp_ready=0 for 5 cycles → rsp_valid stays high, rsp_y=0x40800000 and rsp_id=2 stable, req_ready=0 for all; after rsp_ready=1, one cycle later the next pending requester is granted.
- Pointer skip/wrap: rr_ptr=3 after grant to 2; only req_valid[1] high → grant 1, rr_ptr becomes 2; then req_valid[3] only → grant 3, rr_ptr=0.
- Reset mid-op: assert rst_n=0 during RESP with rsp_valid=1 → rsp_valid, busy, req_ready, add_a, add_b and rsp_y go 0 immediately without a clock; after release with req_valid=0001, requester 0 is granted first.
- Zero/special pass-through: 0x00000000 + 0xC0A00000 → rsp_y=0xC0A00000; 0x7F7FFFFF + 0x7F7FFFFF → rsp_y=0x7F800000.

Source files
------------

// File: rtl/fp32_add_arbiter.sv
// fp32_add_arbiter
// Shares one external combinational fp32 adder between NREQ requesters.
// One operand pair is accepted at a time by round-robin arbitration. It is
// registered onto the adder inputs, and the sum is captured one cycle later.
// The sum is then returned with the requester index on a valid/ready channel.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/req_ready per-requester handshake (req_ready is at most one-hot)
//   req_a, req_b        packed operands, requester i at [32*i +: 32]
//   add_a, add_b, add_y registered operands to the shared adder, and its result
//   rsp_valid/rsp_ready response handshake
//   rsp_y, rsp_id       sum, and the index of the requester that issued it
//   busy                high whenever the arbiter is not idle
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | searching for a requester; a grant loads the adder operands
// EXEC  | adder inputs stable; the sum is captured at the end of this cycle
// RESP  | response held until rsp_ready

module fp32_add_arbiter #(
  parameter  int NREQ = 4,
  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  output logic [31:0]          add_a,
  output logic [31:0]          add_b,
  input  logic [31:0]          add_y,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_y,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [31:0]     add_a_q, add_a_d;
  logic [31:0]     add_b_q, add_b_d;
  logic [31:0]     rsp_y_q, rsp_y_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;

  logic            gnt_any;
  logic [ID_W-1:0] gnt_idx;
  logic [ID_W-1:0] scan_idx;

  // The first valid requester at or after rr_ptr wins, wrapping modulo NREQ.
  // NREQ need not be a power of two, so the wrap is an explicit modulo.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = ID_W'((int'(rr_ptr_q) + k) % NREQ);
      if (!gnt_any && req_valid[scan_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = scan_idx;
      end
    end
  end

  // Gated by rst_n so that asserting reset clears req_ready at once, without
  // waiting for a clock edge.
  always_comb begin
    req_ready = '0;
    if (rst_n && state_q == S_IDLE && gnt_any) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    add_a_d  = add_a_q;
    add_b_d  = add_b_q;
    rsp_y_d  = rsp_y_q;
    rsp_id_d = rsp_id_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_any) begin
          add_a_d  = req_a[int'(gnt_idx)*32 +: 32];
          add_b_d  = req_b[int'(gnt_idx)*32 +: 32];
          id_d     = gnt_idx;
          rr_ptr_d = (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
          state_d  = S_EXEC;
        end
      end
      S_EXEC: begin
        rsp_y_d  = add_y;
        rsp_id_d = id_q;
        state_d  = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      add_a_q  <= '0;
      add_b_q  <= '0;
      rsp_y_q  <= '0;
      rsp_id_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      add_a_q  <= add_a_d;
      add_b_q  <= add_b_d;
      rsp_y_q  <= rsp_y_d;
      rsp_id_q <= rsp_id_d;
    end
  end

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_valid = (state_q == S_RESP);
  assign busy      = (state_q != S_IDLE);

endmodule
